// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared mode encoding and FSM state type for universal_shift_reg
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ASR  = 3'd4,
        MODE_ROL  = 3'd5,
        MODE_ROR  = 3'd6,
        MODE_RSVD = 3'd7
    } usr_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } usr_state_e;

endpackage

// File: rtl/usr_shift_step.sv
// rtl/usr_shift_step.sv - single-step next-value logic; rotate modes exist only with USR_ROTATE_EN
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] a_next
);

    always_comb begin
        a_next = a;
        case (usr_mode_e'(mode))
            MODE_SHL: a_next = {a[WIDTH-2:0], sin_l};
            MODE_SHR: a_next = {sin_r, a[WIDTH-1:1]};
            MODE_ASR: a_next = {a[WIDTH-1], a[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
            MODE_ROL: a_next = {a[WIDTH-2:0], a[WIDTH-1]};
            MODE_ROR: a_next = {a[0], a[WIDTH-1:1]};
`else
            MODE_ROL, MODE_ROR: a_next = a;
`endif
            default:  a_next = a;
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - multi-step universal shift register with load/shift/rotate FSM
// Rotate modes are built only when USR_ROTATE_EN is defined.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CW-1:0]    count,
    input  logic [WIDTH-1:0] I,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] A,
    output logic             busy,
    output logic             done
);

    usr_state_e       state_q;
    logic [2:0]       mode_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic             busy_q;
    logic             done_q;

    usr_shift_step #(.WIDTH(WIDTH)) u_step (
        .mode   (mode_q),
        .a      (a_q),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .a_next (a_d)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            cnt_q   <= '0;
            a_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (usr_mode_e'(mode) == MODE_LOAD) begin
                            a_q    <= I;
                            done_q <= 1'b1;
                        end else if (count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            mode_q  <= mode;
                            cnt_q   <= count;
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // start, mode, count and I are deliberately ignored here
                    a_q   <= a_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign A    = a_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 6, meaning the register width in bits (minimum 2).
REQ-002 SHALL have parameter CW, default 4, meaning the width of the step-count input.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port mode, input, 3 bits: operation select, sampled only with start.
REQ-006 SHALL have port start, input, 1 bit: operation request.
REQ-007 SHALL have port count, input, CW bits: number of shift steps, sampled only with start.
REQ-008 SHALL have port I, input, WIDTH bits: parallel load data.
REQ-009 SHALL have port sin_l, input, 1 bit: serial bit that enters the LSB on a left shift, sampled on every step.
REQ-010 SHALL have port sin_r, input, 1 bit: serial bit that enters the MSB on a logical right shift, sampled on every step.
REQ-011 SHALL have port A, output, WIDTH bits: register contents, driven directly from flops.
REQ-012 SHALL have port busy, output, 1 bit: high while a multi-step operation is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 SHALL use these mode codes: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ASR, 5 ROL, 6 ROR, 7 reserved (behaves as HOLD).
REQ-015 SHALL implement a two-state FSM, IDLE and RUN; it enters IDLE on reset.
REQ-016 SHALL, in IDLE at an edge with start=1 and mode=LOAD, set A<=I at that edge, pulse done high for the following cycle, and keep busy=0.
REQ-017 SHALL, in IDLE at an edge with start=1, any non-LOAD mode and count=0, leave A unchanged, pulse done for the following cycle, and keep busy=0.
REQ-018 SHALL, in IDLE at an edge with start=1, any non-LOAD mode and count=N>0, latch mode and N, enter RUN and set busy=1; A is unchanged at this edge.
REQ-019 SHALL, in RUN, apply exactly one step per edge for N edges; at the Nth step edge it shall return to IDLE, set busy=0 and set done=1 for one cycle. Total latency from start to done is N+1 edges.
REQ-020 SHALL perform each step as follows:
- SHL: {A[W-2:0], sin_l}
- SHR: {sin_r, A[W-1:1]}
- ASR: {A[W-1], A[W-1:1]}
- ROL: {A[W-2:0], A[W-1]}
- ROR: {A[0], A[W-1:1]}
- HOLD and reserved: A unchanged, but steps are still counted.
REQ-021 SHALL ignore start while busy=1; mode, count and I changes during RUN have no effect.
REQ-022 SHALL allow N to exceed WIDTH; steps continue normally, e.g. SHL with sin_l=0 reaches all zeros.
REQ-023 SHALL accept a new start in IDLE on the same cycle that done is high.

Reset
REQ-024 SHALL, when Reset=1 at any time (including mid-RUN), immediately force A=0, busy=0, done=0, state=IDLE and the internal step counter to 0, independent of clk.
REQ-025 SHALL resume normal operation at the first rising clk edge after Reset deasserts.

Configuration
REQ-026 SHALL compile the rotate modes only when USR_ROTATE_EN is defined.
- With USR_ROTATE_EN defined: ROL and ROR step as in REQ-020.
- Without it: codes 5 and 6 behave as HOLD (steps counted, A unchanged) and no rotate logic is synthesised.

Structure
REQ-027 SHALL place the mode encoding (3-bit enum of REQ-014) and the FSM state type in the shared package usr_pkg.
REQ-028 SHALL implement single-step next-value logic in one combinational sub-module, usr_shift_step (inputs mode, A, sin_l, sin_r; output next A); the top level holds the FSM, the counter and the registers.

Verification (WIDTH=6, CW=4)
REQ-029 SHALL cover: Reset pulse, then start with LOAD and I=12 -> A=001100 after one edge, done high for 1 cycle, busy stays 0.
REQ-030 SHALL cover: A=001100, SHL, count=2, sin_l=1 -> busy for 2 cycles, A=011001 then 110011, done at edge 3.
REQ-031 SHALL cover: A=100100, ASR, count=3 -> A=110010, 111001, 111100, then a done pulse.
REQ-032 SHALL cover: A=101100, ROL, count=1 -> A=011001 with USR_ROTATE_EN defined; A stays 101100 without it; done pulses in both builds.
REQ-033 SHALL cover: SHR, count=5, with start re-asserted during busy (ignored), then Reset asserted after the 2nd step -> A=000000 and busy=0 immediately, with no done pulse.
REQ-034 SHALL cover: SHR, count=0 -> A unchanged, done pulses one cycle after start, busy never rises.
